// File: rtl/wave_freq_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : wave_freq_meter
// Description : Counts DDS address wraps over a gate window, converts the
//               count to BCD and drives a 4-digit multiplexed 7-seg display.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_freq_meter #(
    parameter int ADDR_W     = 8,
    parameter int GATE_TICKS = 10000,
    parameter int SCAN_DIV   = 25,
    parameter int MAX_CNT    = 9999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en,
    input  logic [ADDR_W-1:0] address,
    output logic [15:0]       bcd,
    output logic              bcd_valid,
    output logic              ovf,
    output logic [3:0]        dis_duan_1,
    output logic [6:0]        dis_wei_1
);

    localparam int GW = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [GW-1:0] C_GATE_LAST = GW'(GATE_TICKS - 1);
    localparam logic [SW-1:0] C_SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [13:0]   C_MAX       = 14'(MAX_CNT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic            r_prev_msb;
    logic [13:0]     r_wrap_cnt;
    logic            r_sat;
    logic [GW-1:0]   r_gate_cnt;
    logic            r_hold_ovf;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_iter;
    logic [29:0]     r_sr;
    logic [29:0]     w_sr_adj;
    logic [15:0]     r_bcd;
    logic            r_bcd_valid;
    logic            r_ovf;
    logic [SW-1:0]   r_scan_cnt;
    logic [1:0]      r_dig_idx;
    logic [3:0]      r_duan;
    logic [6:0]      r_wei;

    logic            w_wrap;
    logic            w_at_max;
    logic [13:0]     w_cnt_next;
    logic            w_sat_next;
    logic            w_start;
    logic            w_load;
    logic            w_shift;
    logic            w_done;
    logic [3:0]      w_nib;
    logic            w_blank;
    logic [6:0]      w_seg;
    logic            w_unused;

    // Only the MSB of the address matters for wrap detection.
    assign w_unused = ^address[ADDR_W-2:0];

    assign w_wrap     = tick_en & r_prev_msb & ~address[ADDR_W-1];
    assign w_at_max   = (r_wrap_cnt >= C_MAX);
    assign w_cnt_next = (w_wrap && !w_at_max) ? r_wrap_cnt + 14'd1 : r_wrap_cnt;
    assign w_sat_next = r_sat | (w_wrap & w_at_max);
    assign w_start    = tick_en && (r_gate_cnt == C_GATE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_msb <= 1'b0;
            r_wrap_cnt <= '0;
            r_sat      <= 1'b0;
            r_gate_cnt <= '0;
            r_hold_ovf <= 1'b0;
        end else if (tick_en) begin
            r_prev_msb <= address[ADDR_W-1];
            if (w_start) begin
                r_gate_cnt <= '0;
                r_wrap_cnt <= '0;
                r_sat      <= 1'b0;
                r_hold_ovf <= w_sat_next;
            end else begin
                r_gate_cnt <= r_gate_cnt + GW'(1);
                r_wrap_cnt <= w_cnt_next;
                r_sat      <= w_sat_next;
            end
        end
    end

    // Converter FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Converter FSM: next state; a new start always restarts the conversion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_start)
                    w_state_nxt = S_SHIFT;
                else if (r_iter == 4'd13)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = w_start ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Converter FSM: outputs
    always_comb begin
        w_load  = w_start;
        w_shift = (r_state == S_SHIFT) && !w_start;
        w_done  = (r_state == S_DONE) && !w_start;
    end

    always_comb begin
        w_sr_adj = r_sr;
        for (int k = 0; k < 4; k++) begin
            if (r_sr[14+4*k +: 4] >= 4'd5)
                w_sr_adj[14+4*k +: 4] = r_sr[14+4*k +: 4] + 4'd3;
        end
    end

    // The hold value is loaded straight from the closing-gate count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_iter      <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= w_done;
            if (w_load) begin
                r_sr   <= {16'b0, w_cnt_next};
                r_iter <= '0;
            end else if (w_shift) begin
                r_sr   <= {w_sr_adj[28:0], 1'b0};
                r_iter <= r_iter + 4'd1;
            end
            if (w_done) begin
                r_bcd <= r_sr[29:14];
                r_ovf <= r_hold_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
        end else if (tick_en) begin
            if (r_scan_cnt == C_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_dig_idx  <= r_dig_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SW'(1);
            end
        end
    end

    assign w_nib = r_bcd[{r_dig_idx, 2'b00} +: 4];

    // Leading-zero blanking; the ones digit is never blanked.
    always_comb begin
        case (r_dig_idx)
            2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
            2'd2:    w_blank = (r_bcd[15:8] == 8'd0);
            2'd1:    w_blank = (r_bcd[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end

    always_comb begin
        case (w_nib)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duan <= 4'b0001;
            r_wei  <= 7'h3F;
        end else begin
            r_duan <= 4'b0001 << r_dig_idx;
            r_wei  <= w_blank ? 7'h00 : w_seg;
        end
    end

    assign bcd        = r_bcd;
    assign bcd_valid  = r_bcd_valid;
    assign ovf        = r_ovf;
    assign dis_duan_1 = r_duan;
    assign dis_wei_1  = r_wei;

endmodule
`default_nettype wire
